// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI-driven PWM configuration block.
package spi_pwm_pkg;
    localparam int FRAME_BITS = 16;
    localparam int MAX_ADDR   = 4;
    localparam int CNT_W      = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;
endpackage

// File: rtl/spi_pwm_cfg_ctrl_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered rise/fall pulses.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // Clearing to 0 means a chip select already low when reset releases
    // produces no false falling edge, so a half-sent frame is never picked up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI mode-0 write-only slave, oversampled in clk, committing 16-bit frames
// into the PWM output-enable / duty configuration registers.
module spi_pwm_cfg_ctrl
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_pwm_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = spi_pwm_pkg::MAX_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       copi_in,
    input  logic       ncs_in,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       cfg_update,
    output logic       frame_err
);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
    logic w_unused_sclk;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sclk_in),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ncs_in),
        .o_level (w_ncs_lvl),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    assign w_unused_sclk = w_sclk_lvl ^ w_sclk_fall;

    // Data only needs its level; it is stable around the delayed SCLK rise pulse.
    logic [SYNC_STAGES-1:0] r_copi_sync;
    always_ff @(posedge clk) begin
        if (rst) r_copi_sync <= '0;
        else     r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi_in};
    end

    state_t                r_state, w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_fall_hold;
    logic                  w_fall_any;
    logic                  w_shift_en;
    logic                  w_commit_ok;
    logic                  w_commit_bad;
    logic [6:0]            w_addr;
    logic [7:0]            w_data;

    assign w_addr = r_shift[FRAME_BITS-2 -: 7];
    assign w_data = r_shift[7:0];

    // A chip-select fall that lands during COMMIT is replayed one cycle later.
    assign w_fall_any = w_ncs_fall | r_fall_hold;

    // A chip-select rise wins over a coincident SCLK rise.
    assign w_shift_en = (r_state == SHIFT) & w_sclk_rise & ~w_ncs_rise & ~w_ncs_lvl;

    assign w_commit_ok  = (r_state == COMMIT) && (r_cnt == CNT_FULL) &&
                          r_shift[FRAME_BITS-1] && (w_addr <= 7'(MAX_ADDR));
    assign w_commit_bad = (r_state == COMMIT) && (r_cnt != CNT_FULL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fall_any) w_state_nxt = SHIFT;
            SHIFT:   if (w_ncs_rise) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_fall_hold <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fall_hold <= (r_state == COMMIT) & w_ncs_fall;
            if (r_state == IDLE && w_fall_any) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], r_copi_sync[SYNC_STAGES-1]};
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            cfg_update      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            cfg_update <= w_commit_ok;
            frame_err  <= w_commit_bad;
            if (w_commit_ok) begin
                case (w_addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= w_data;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= w_data;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= w_data;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= w_data;
                    ADDR_DUTY:      pwm_duty_cycle  <= w_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Directed bench: drives SPI frames at 1/8 of clk and checks the register bank and pulses.
module tb_spi_pwm_cfg_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_in = 1'b0;
    logic       copi_in = 1'b0;
    logic       ncs_in = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       cfg_update, frame_err;

    int n_vec = 0;
    int n_err = 0;
    int n_upd = 0;
    int n_ferr = 0;
    int upd0, ferr0;

    spi_pwm_cfg_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .sclk_in         (sclk_in),
        .copi_in         (copi_in),
        .ncs_in          (ncs_in),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .cfg_update      (cfg_update),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_update === 1'b1) n_upd++;
        if (frame_err === 1'b1) n_ferr++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bits(input logic [16:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi_in = bits[i];
            tick(4);
            sclk_in = 1'b1;
            tick(4);
            sclk_in = 1'b0;
        end
    endtask

    // Trailing 16-clk idle doubles as the 2-SCLK-period inter-frame gap.
    task automatic frame(input logic [16:0] bits, input int n);
        ncs_in = 1'b0;
        tick(4);
        shift_bits(bits, n);
        tick(4);
        ncs_in = 1'b1;
        tick(16);
    endtask

    task automatic chk_regs(input string tag, input logic [39:0] exp);
        chk({tag, ".r0"}, {24'h0, en_reg_out_7_0},  {24'h0, exp[39:32]});
        chk({tag, ".r1"}, {24'h0, en_reg_out_15_8}, {24'h0, exp[31:24]});
        chk({tag, ".r2"}, {24'h0, en_reg_pwm_7_0},  {24'h0, exp[23:16]});
        chk({tag, ".r3"}, {24'h0, en_reg_pwm_15_8}, {24'h0, exp[15:8]});
        chk({tag, ".r4"}, {24'h0, pwm_duty_cycle},  {24'h0, exp[7:0]});
    endtask

    initial begin
        tick(5);
        chk_regs("reset", 40'h00_00_00_00_00);
        chk("reset.upd", {31'h0, cfg_update}, 32'h0);
        chk("reset.ferr", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        tick(5);

        // 1: single write to addr 0
        upd0 = n_upd;
        frame(17'h080FF, 16);
        chk_regs("t1", 40'hFF_00_00_00_00);
        chk("t1.upd", n_upd - upd0, 1);

        // 2: duty write then a read frame to the same address
        upd0 = n_upd;
        frame(17'h08480, 16);
        chk("t2.duty_w", {24'h0, pwm_duty_cycle}, 32'h80);
        frame(17'h00411, 16);
        chk_regs("t2", 40'hFF_00_00_00_80);
        chk("t2.upd", n_upd - upd0, 1);

        // 3: write to unimplemented address
        upd0 = n_upd; ferr0 = n_ferr;
        frame(17'h085AA, 16);
        chk_regs("t3", 40'hFF_00_00_00_80);
        chk("t3.upd", n_upd - upd0, 0);
        chk("t3.ferr", n_ferr - ferr0, 0);

        // 4: short then long frames
        upd0 = n_upd; ferr0 = n_ferr;
        frame(17'h0407F, 15);
        chk("t4.ferr15", n_ferr - ferr0, 1);
        frame(17'h101FE, 17);
        chk("t4.ferr17", n_ferr - ferr0, 2);
        chk_regs("t4", 40'hFF_00_00_00_80);
        chk("t4.upd", n_upd - upd0, 0);

        // 5: reset mid-frame; the tail of that frame must not count
        ncs_in = 1'b0;
        tick(4);
        shift_bits(17'h00082, 8);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        upd0 = n_upd; ferr0 = n_ferr;
        shift_bits(17'h0005A, 8);
        tick(4);
        ncs_in = 1'b1;
        tick(16);
        chk_regs("t5.partial", 40'h00_00_00_00_00);
        chk("t5.upd_partial", n_upd - upd0, 0);
        chk("t5.ferr_partial", n_ferr - ferr0, 0);
        frame(17'h0825A, 16);
        chk_regs("t5", 40'h00_00_5A_00_00);
        chk("t5.upd", n_upd - upd0, 1);

        // 6: back-to-back writes to addrs 1..4
        upd0 = n_upd; ferr0 = n_ferr;
        frame(17'h08111, 16);
        frame(17'h08222, 16);
        frame(17'h08333, 16);
        frame(17'h08444, 16);
        chk_regs("t6", 40'h00_11_22_33_44);
        chk("t6.upd", n_upd - upd0, 4);
        chk("t6.ferr", n_ferr - ferr0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
